// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit ALU stage and its command controller:
// opcode encoding and controller FSM state encoding.
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_LSL = 2'b10;
  localparam logic [1:0] OP_LSR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/alu_stage.sv
// Registered ALU (ADD/SUB/LSL/LSR, shifts by one bit) with a LATENCY-deep
// output pipeline and no handshake.
module alu_stage
  import alu_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int LATENCY = 1
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [1:0]        iOPCODE,
  input  logic [DATA_W-1:0] iDATAIN1,
  input  logic [DATA_W-1:0] iDATAIN2,
  output logic [DATA_W-1:0] oDATAOUT
);

  logic [DATA_W-1:0] result_d;
  logic [DATA_W-1:0] pipe_q [LATENCY];

  always_comb begin
    result_d = '0;
    case (iOPCODE)
      OP_ADD:  result_d = iDATAIN1 + iDATAIN2;
      OP_SUB:  result_d = iDATAIN1 - iDATAIN2;
      OP_LSL:  result_d = {iDATAIN1[DATA_W-2:0], 1'b0};
      default: result_d = {1'b0, iDATAIN1[DATA_W-1:1]};
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      for (int i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= result_d;
      for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign oDATAOUT = pipe_q[LATENCY-1];

endmodule

// File: rtl/alu_cmd_ctrl.sv
// Valid/ready command front-end for the registered ALU: issues one command,
// waits out the ALU latency, captures result plus carry/shift-out flag.
module alu_cmd_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ALU_LATENCY = 1,
  parameter int CNT_W       = 16
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iCMD_VALID,
  output logic              oCMD_READY,
  input  logic [1:0]        iCMD_OPCODE,
  input  logic [DATA_W-1:0] iCMD_A,
  input  logic [DATA_W-1:0] iCMD_B,
  output logic [1:0]        oALU_OPCODE,
  output logic [DATA_W-1:0] oALU_DATAIN1,
  output logic [DATA_W-1:0] oALU_DATAIN2,
  input  logic [DATA_W-1:0] iALU_DATAOUT,
  output logic              oRES_VALID,
  input  logic              iRES_READY,
  output logic [DATA_W-1:0] oRES_DATA,
  output logic              oRES_FLAG,
  output logic [CNT_W-1:0]  oOP_CNT
);

  localparam logic [3:0] LAT_INIT = 4'(ALU_LATENCY);

  state_t            state_q, state_d;
  logic [3:0]        lat_q, lat_d;
  logic [1:0]        alu_op_q, alu_op_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic              res_valid_q, res_valid_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic              res_flag_q, res_flag_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Flag depends only on the operands, so it is computed at accept time
  // rather than reconstructed from the ALU output.
  function automatic logic calc_flag(input logic [1:0] op,
                                     input logic [DATA_W-1:0] a,
                                     input logic [DATA_W-1:0] b);
    logic [DATA_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    case (op)
      OP_ADD:  calc_flag = sum[DATA_W];
      OP_SUB:  calc_flag = (a < b);
      OP_LSL:  calc_flag = a[DATA_W-1];
      default: calc_flag = a[0];
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    alu_op_d    = alu_op_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_flag_d  = res_flag_q;
    cnt_d       = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (iCMD_VALID) begin
          alu_op_d   = iCMD_OPCODE;
          alu_a_d    = iCMD_A;
          alu_b_d    = iCMD_B;
          res_flag_d = calc_flag(iCMD_OPCODE, iCMD_A, iCMD_B);
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        lat_d   = LAT_INIT;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        lat_d = lat_q - 4'd1;
        if (lat_q == 4'd1) begin
          res_data_d  = iALU_DATAOUT;
          res_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end
      default: begin
        if (iRES_READY) begin
          res_valid_d = 1'b0;
          cnt_d       = cnt_q + 1'b1;
          state_d     = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q     <= ST_IDLE;
      lat_q       <= '0;
      alu_op_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_flag_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      alu_op_q    <= alu_op_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_flag_q  <= res_flag_d;
      cnt_q       <= cnt_d;
    end
  end

  // Ready is masked during reset so nothing is offered in the reset cycle.
  assign oCMD_READY   = (state_q == ST_IDLE) && !iRST;
  assign oALU_OPCODE  = alu_op_q;
  assign oALU_DATAIN1 = alu_a_q;
  assign oALU_DATAIN2 = alu_b_q;
  assign oRES_VALID   = res_valid_q;
  assign oRES_DATA    = res_data_q;
  assign oRES_FLAG    = res_flag_q;
  assign oOP_CNT      = cnt_q;

endmodule
